// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared types and constants for the seven-segment scan controller.
// Holds the FSM state enum, the active-low segment codes (bit7 = DP, always
// off), the active-low digit-select patterns and a digit-to-segment decoder.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] DIG_ONES = 4'b1110;
    localparam logic [3:0] DIG_TENS = 4'b1101;
    localparam logic [3:0] DIG_HUNS = 4'b1011;
    localparam logic [3:0] DIG_THOU = 4'b0111;
    localparam logic [3:0] DIG_OFF  = 4'hF;

    // Nibbles above 9 cannot come out of a correct conversion; show "0".
    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_bcd_shift8.sv
// bcd_shift8: sequential double-dabble datapath for an 8-bit binary value.
// Ports: clk, rst (sync, active-high); load captures bin and clears the BCD
// digits; step performs one add-3-then-shift. Outputs hun[1:0], ten[3:0],
// one[3:0] are valid after load plus eight steps. Sequencing is external.
module bcd_shift8
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] bin,
    output logic [1:0] hun,
    output logic [3:0] ten,
    output logic [3:0] one
);

    logic [7:0] bin_q, bin_d;
    logic [1:0] hun_q, hun_d;
    logic [3:0] ten_q, ten_d;
    logic [3:0] one_q, one_d;
    logic [3:0] ten_adj;
    logic [3:0] one_adj;

    always_comb begin
        ten_adj = (ten_q >= 4'd5) ? ten_q + 4'd3 : ten_q;
        one_adj = (one_q >= 4'd5) ? one_q + 4'd3 : one_q;
        bin_d   = bin_q;
        hun_d   = hun_q;
        ten_d   = ten_q;
        one_d   = one_q;
        if (load) begin
            bin_d = bin;
            hun_d = 2'd0;
            ten_d = 4'd0;
            one_d = 4'd0;
        end else if (step) begin
            // Hundreds never exceeds 2 for 8-bit input, so it needs no adjust.
            {hun_d, ten_d, one_d, bin_d} = {hun_q[0], ten_adj, one_adj, bin_q, 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q <= 8'd0;
            hun_q <= 2'd0;
            ten_q <= 4'd0;
            one_q <= 4'd0;
        end else begin
            bin_q <= bin_d;
            hun_q <= hun_d;
            ten_q <= ten_d;
            one_q <= one_d;
        end
    end

    assign hun = hun_q;
    assign ten = ten_q;
    assign one = one_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: accepts an 8-bit value over valid/ready, converts it to BCD
// and multiplexes the digits onto a 4-digit common-anode display.
// Ports: clk, rst (sync, active-high), in_valid/in_data/in_ready handshake,
// busy (conversion in flight), DIG (active-low one-hot digit select, reg),
// Y (active-low segments, DP always off, reg).
//
// state | meaning
// IDLE  | waiting for a value, in_ready high
// CONV  | eight add-3/shift steps, one per cycle
// LOAD  | copy converter result into the displayed digit registers
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       busy,
    output logic [3:0] DIG,
    output logic [7:0] Y
);

    localparam logic [19:0] PRESC_LAST = 20'(SCAN_DIV - 1);

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [19:0] presc_q, presc_d;
    logic [1:0] slot_q, slot_d;
    logic [1:0] dig_hun_q, dig_hun_d;
    logic [3:0] dig_ten_q, dig_ten_d;
    logic [3:0] dig_one_q, dig_one_d;
    logic [3:0] dig_out_q, dig_out_d;
    logic [7:0] y_q, y_d;

    logic       cv_load;
    logic       cv_step;
    logic [1:0] cv_hun;
    logic [3:0] cv_ten;
    logic [3:0] cv_one;
    logic       tick;

    bcd_shift8 u_bcd (
        .clk  (clk),
        .rst  (rst),
        .load (cv_load),
        .step (cv_step),
        .bin  (in_data),
        .hun  (cv_hun),
        .ten  (cv_ten),
        .one  (cv_one)
    );

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cv_load   = 1'b0;
        cv_step   = 1'b0;
        dig_hun_d = dig_hun_q;
        dig_ten_d = dig_ten_q;
        dig_one_d = dig_one_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cv_load = 1'b1;
                    step_d  = 3'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                cv_step = 1'b1;
                if (step_q == 3'd7) begin
                    state_d = LOAD;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            LOAD: begin
                dig_hun_d = cv_hun;
                dig_ten_d = cv_ten;
                dig_one_d = cv_one;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running scan, independent of the conversion FSM.
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? 20'd0 : presc_q + 20'd1;
        slot_d  = tick ? slot_q + 2'd1 : slot_q;
    end

    always_comb begin
        dig_out_d = DIG_OFF;
        y_d       = SEG_BLANK;
        case (slot_q)
            2'd0: begin
                dig_out_d = DIG_ONES;
                y_d       = seg_code(dig_one_q);
            end
            2'd1: begin
                dig_out_d = DIG_TENS;
                y_d       = (LZ_BLANK && dig_hun_q == 2'd0 && dig_ten_q == 4'd0)
                            ? SEG_BLANK : seg_code(dig_ten_q);
            end
            2'd2: begin
                dig_out_d = DIG_HUNS;
                y_d       = (LZ_BLANK && dig_hun_q == 2'd0)
                            ? SEG_BLANK : seg_code({2'b00, dig_hun_q});
            end
            default: begin
                dig_out_d = DIG_THOU;
                y_d       = LZ_BLANK ? SEG_BLANK : SEG_0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            step_q    <= 3'd0;
            presc_q   <= 20'd0;
            slot_q    <= 2'd0;
            dig_hun_q <= 2'd0;
            dig_ten_q <= 4'd0;
            dig_one_q <= 4'd0;
            dig_out_q <= DIG_OFF;
            y_q       <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            presc_q   <= presc_d;
            slot_q    <= slot_d;
            dig_hun_q <= dig_hun_d;
            dig_ten_q <= dig_ten_d;
            dig_one_q <= dig_one_d;
            dig_out_q <= dig_out_d;
            y_q       <= y_d;
        end
    end

    assign in_ready = (state_q == IDLE) && !rst;
    assign busy     = (state_q == CONV) || (state_q == LOAD);
    assign DIG      = dig_out_q;
    assign Y        = y_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (leading-zero blanking on and off)
// share stimulus and are compared every cycle against a behavioural model
// built from value/100, (value/10)%10, value%10 and cycle counting.
module tb_seg_scan_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       ready1, busy1, ready0, busy0;
    logic [3:0] dig1, dig0;
    logic [7:0] y1, y0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.SCAN_DIV(DIV), .LZ_BLANK(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready1), .busy(busy1), .DIG(dig1), .Y(y1)
    );

    seg_scan_ctrl #(.SCAN_DIV(DIV), .LZ_BLANK(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready0), .busy(busy0), .DIG(dig0), .Y(y0)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [7:0] exp_y(input int v, input int s, input bit lz);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        case (s)
            0:       return seg_tab[o];
            1:       return (lz && h == 0 && t == 0) ? 8'hFF : seg_tab[t];
            2:       return (lz && h == 0) ? 8'hFF : seg_tab[h];
            default: return lz ? 8'hFF : 8'hC0;
        endcase
    endfunction

    int         m_since = 1000;   // edges since last accept (1000 = none pending)
    int         m_pend  = 0;
    int         m_shown = 0;
    int         m_n     = 0;      // non-reset edges since last reset edge
    int         m_s;
    bit         m_rdy;
    bit         m_en    = 1'b0;
    logic [3:0] m_dig;
    logic [7:0] m_y1, m_y0;

    always @(posedge clk) begin
        if (rst) begin
            m_since = 1000;
            m_shown = 0;
            m_n     = 0;
            m_dig   = 4'hF;
            m_y1    = 8'hFF;
            m_y0    = 8'hFF;
            m_en    = 1'b1;
        end else begin
            m_s   = (m_n / DIV) % 4;
            m_dig = 4'hF ^ (4'h1 << m_s);
            m_y1  = exp_y(m_shown, m_s, 1'b1);
            m_y0  = exp_y(m_shown, m_s, 1'b0);
            m_rdy = (m_since >= 9);
            if (m_since < 1000) m_since++;
            if (m_since == 9) m_shown = m_pend;
            if (in_valid && m_rdy) begin
                m_since = 0;
                m_pend  = int'(in_data);
            end
            m_n++;
        end
    end

    always @(negedge clk) begin
        if (m_en) begin
            chk("ready1", ready1, !rst && m_since >= 9);
            chk("ready0", ready0, !rst && m_since >= 9);
            chk("busy1", busy1, m_since < 9);
            chk("busy0", busy0, m_since < 9);
            chk("dig1", dig1, m_dig);
            chk("dig0", dig0, m_dig);
            chk("y1", y1, m_y1);
            chk("y0", y0, m_y0);
        end
    end

    // ---------------- stimulus helpers ----------------
    // All tasks start and end 1 time unit after a posedge.
    task automatic send(input logic [7:0] v);
        bit r;
        int b;
        in_valid = 1'b1;
        in_data  = v;
        b = 0;
        r = 1'b0;
        while (!r && b < 100) begin
            @(negedge clk);
            r = ready1;
            @(posedge clk);
            b++;
        end
        #1 in_valid = 1'b0;
        if (!r) chk("send_timeout", 8'd0, 8'd1);
    endtask

    task automatic wait_ready(output int lows);
        lows = 0;
        @(negedge clk);
        while (!ready1 && lows < 100) begin
            lows++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_slot(input bit sel1, input logic [3:0] pat,
                               input logic [7:0] yexp, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if ((sel1 ? dig1 : dig0) == pat) found = 1'b1;
        end
        chk({name, "_dig"}, sel1 ? dig1 : dig0, pat);
        chk(name, sel1 ? y1 : y0, yexp);
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lows, acc1, acc2;
        bit r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dig", dig1, 4'hF);
        chk("rst_y", y1, 8'hFF);
        chk("rst_ready", ready1, 1'b0);
        chk("rst_busy", busy1, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rel_dig", dig1, 4'b1110);
        chk("rel_y", y1, 8'hC0);
        chk("rel_ready", ready1, 1'b1);
        @(posedge clk);
        #1;

        // 255
        send(8'd255);
        wait_ready(lows);
        chk("lat255_low_cycles", 8'(lows), 8'd9);
        expect_slot(1'b1, 4'b1011, 8'hA4, "v255_hun");
        expect_slot(1'b1, 4'b1101, 8'h92, "v255_ten");
        expect_slot(1'b1, 4'b1110, 8'h92, "v255_one");
        expect_slot(1'b1, 4'b0111, 8'hFF, "v255_thou");

        // 7, with and without blanking
        send(8'd7);
        wait_ready(lows);
        expect_slot(1'b1, 4'b1011, 8'hFF, "v7_lz_hun");
        expect_slot(1'b1, 4'b1101, 8'hFF, "v7_lz_ten");
        expect_slot(1'b1, 4'b1110, 8'hF8, "v7_lz_one");
        expect_slot(1'b0, 4'b1011, 8'hC0, "v7_nolz_hun");
        expect_slot(1'b0, 4'b1101, 8'hC0, "v7_nolz_ten");
        expect_slot(1'b0, 4'b0111, 8'hC0, "v7_nolz_thou");

        // 105: embedded zero stays visible
        send(8'd105);
        wait_ready(lows);
        expect_slot(1'b1, 4'b1101, 8'hC0, "v105_ten");
        expect_slot(1'b1, 4'b1011, 8'hF9, "v105_hun");

        // back-to-back 42 then 199
        in_valid = 1'b1;
        in_data  = 8'd42;
        acc1 = -1;
        acc2 = -1;
        for (int e = 0; e < 60 && acc2 < 0; e++) begin
            @(negedge clk);
            r = ready1;
            @(posedge clk);
            if (r) begin
                if (acc1 < 0) begin
                    acc1 = e;
                    #1 in_data = 8'd199;
                end else begin
                    acc2 = e;
                end
            end
        end
        #1 in_valid = 1'b0;
        chk("b2b_gap", 8'(acc2 - acc1), 8'd10);
        wait_ready(lows);
        expect_slot(1'b1, 4'b1011, 8'hF9, "v199_hun");
        expect_slot(1'b1, 4'b1101, 8'h90, "v199_ten");
        expect_slot(1'b1, 4'b1110, 8'h90, "v199_one");

        // abort mid-conversion
        send(8'd88);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        expect_slot(1'b1, 4'b1110, 8'hC0, "abort_one");
        expect_slot(1'b1, 4'b1101, 8'hFF, "abort_ten");
        send(8'd88);
        wait_ready(lows);
        expect_slot(1'b1, 4'b1011, 8'hFF, "v88_hun");
        expect_slot(1'b1, 4'b1101, 8'h80, "v88_ten");
        expect_slot(1'b1, 4'b1110, 8'h80, "v88_one");

        // exhaustive sweep, model checks every slot of every value
        for (int v = 0; v < 256; v++) begin
            send(8'(v));
            wait_ready(lows);
            chk("sweep_latency", 8'(lows), 8'd9);
            repeat (4 * DIV) @(posedge clk);
            #1;
        end

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            rst      = ($urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
